// File: rtl/sext_rr_arbiter.sv
// Round-robin arbiter in front of a shared sign-extension datapath.
// One registered result slot with requester ID and a valid/ready output.
module sext_rr_arbiter #(
    parameter  int NUM_REQ   = 4,
    parameter  int IN_WIDTH  = 16,
    parameter  int OUT_WIDTH = 32,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_byte,
    input  logic [NUM_REQ*IN_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_WIDTH-1:0]         out_data,
    output logic [ID_W-1:0]              out_id
);

    generate
        if (OUT_WIDTH <= IN_WIDTH) begin : g_bad_out_width
            $error("sext_rr_arbiter: OUT_WIDTH must exceed IN_WIDTH");
        end
        if (IN_WIDTH < 8) begin : g_bad_in_width
            $error("sext_rr_arbiter: IN_WIDTH must be at least 8");
        end
        if (NUM_REQ < 2) begin : g_bad_num_req
            $error("sext_rr_arbiter: NUM_REQ must be at least 2");
        end
    endgenerate

    // Handshakes: a transfer happens on a cycle where valid and ready are both
    // high at the rising edge; ready never looks at the payload, and a valid
    // requester holds data/byte stable until it sees ready.

    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     winner;
    logic                any_valid;
    logic                slot_free;
    logic                grant;
    logic [IN_WIDTH-1:0] ops [NUM_REQ];

    function automatic logic [OUT_WIDTH-1:0] sext(input logic [IN_WIDTH-1:0] d,
                                                  input logic                b);
        if (b)
            return {{(OUT_WIDTH-8){d[7]}}, d[7:0]};
        else
            return {{(OUT_WIDTH-IN_WIDTH){d[IN_WIDTH-1]}}, d};
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            ops[i] = req_data[i*IN_WIDTH +: IN_WIDTH];
        end
    end

    // First valid index at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] cand;
        idx       = 0;
        cand      = '0;
        any_valid = 1'b0;
        winner    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = ID_W'(idx);
            if (!any_valid && req_valid[cand]) begin
                any_valid = 1'b1;
                winner    = cand;
            end
        end
    end

    assign slot_free = !out_valid || out_ready;
    assign grant     = rst_n && slot_free && any_valid;
    assign req_ready = grant ? (NUM_REQ'(1) << winner) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            rr_ptr    <= '0;
        end else if (grant) begin
            out_valid <= 1'b1;
            out_data  <= sext(ops[winner], req_byte[winner]);
            out_id    <= winner;
            rr_ptr    <= (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sext_rr_arbiter.sv
// Directed bench for sext_rr_arbiter (4 requesters, 16-bit in, 32-bit out).
// Expected values are hand-computed constants checked with immediate assertions.
module tb_sext_rr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int IN_WIDTH  = 16;
    localparam int OUT_WIDTH = 32;
    localparam int ID_W      = 2;

    logic                        clk;
    logic                        rst_n;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_byte;
    logic [NUM_REQ*IN_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]          req_ready;
    logic                        out_valid;
    logic                        out_ready;
    logic [OUT_WIDTH-1:0]        out_data;
    logic [ID_W-1:0]             out_id;

    int checks = 0;
    int errors = 0;

    sext_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_byte (req_byte),
        .req_data (req_data),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_id   (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [3:0]  rr_ready_exp [5];
    logic [1:0]  rr_id_exp    [5];
    logic [31:0] rr_data_exp  [5];

    initial begin
        // Requester operands used by the fairness and backpressure steps.
        rr_ready_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_id_exp    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rr_data_exp  = '{32'hFFFFF00D, 32'h00000080, 32'h00000123, 32'hFFFFFFBC, 32'hFFFFF00D};

        // 1: reset with every requester asking
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_byte  = 4'b0000;
        req_data  = {16'h7ABC, 16'h0123, 16'h0080, 16'hF00D};
        out_ready = 1'b0;
        settle();
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data",  64'(out_data),  64'h0);
        chk("rst_out_id",    64'(out_id),    64'h0);
        tick();
        chk("rst_hold_req_ready", 64'(req_ready), 64'h0);
        chk("rst_hold_out_valid", 64'(out_valid), 64'h0);

        rst_n = 1'b1;
        settle();
        chk("first_grant_ready", 64'(req_ready), 64'h1);
        tick();
        chk("first_grant_valid", 64'(out_valid), 64'h1);
        chk("first_grant_id",    64'(out_id),    64'h0);
        chk("first_grant_data",  64'(out_data),  64'hFFFFF00D);
        chk("stall_no_ready",    64'(req_ready), 64'h0);

        // 2: sign extension, full width and low byte
        out_ready = 1'b1;
        req_valid = 4'b0010;
        req_data  = {16'h7ABC, 16'h0123, 16'h8001, 16'hF00D};
        req_byte  = 4'b0000;
        settle();
        chk("ext_full_ready", 64'(req_ready), 64'h2);
        tick();
        chk("ext_full_data",  64'(out_data),  64'hFFFF8001);
        chk("ext_full_id",    64'(out_id),    64'h1);
        chk("ext_full_valid", 64'(out_valid), 64'h1);

        req_data = {16'h7ABC, 16'h0123, 16'h127F, 16'hF00D};
        req_byte = 4'b0010;
        tick();
        chk("ext_byte_pos_data", 64'(out_data), 64'h0000007F);
        chk("ext_byte_pos_id",   64'(out_id),   64'h1);

        req_data = {16'h7ABC, 16'h0123, 16'h0080, 16'hF00D};
        tick();
        chk("ext_byte_neg_data", 64'(out_data), 64'hFFFFFF80);

        // Pointer is now 2; a lone request from 3 moves it to 0.
        req_valid = 4'b1000;
        req_byte  = 4'b1000;
        tick();
        chk("align_id",   64'(out_id),   64'h3);
        chk("align_data", 64'(out_data), 64'hFFFFFFBC);

        // 3: round-robin with everyone valid and the consumer always ready
        req_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk($sformatf("rr_ready_%0d", i), 64'(req_ready), 64'(rr_ready_exp[i]));
            tick();
            chk($sformatf("rr_id_%0d", i),    64'(out_id),    64'(rr_id_exp[i]));
            chk($sformatf("rr_data_%0d", i),  64'(out_data),  64'(rr_data_exp[i]));
            chk($sformatf("rr_valid_%0d", i), 64'(out_valid), 64'h1);
        end

        // 4: backpressure for three cycles, result from requester 0 pending
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("bp_ready_%0d", i), 64'(req_ready), 64'h0);
            tick();
            chk($sformatf("bp_id_%0d", i),    64'(out_id),    64'h0);
            chk($sformatf("bp_data_%0d", i),  64'(out_data),  64'hFFFFF00D);
            chk($sformatf("bp_valid_%0d", i), 64'(out_valid), 64'h1);
        end
        out_ready = 1'b1;
        settle();
        chk("bp_release_ready", 64'(req_ready), 64'h2);
        tick();
        chk("bp_release_id",   64'(out_id),   64'h1);
        chk("bp_release_data", 64'(out_data), 64'h00000080);

        // 5: skip and wrap; requester 2 alone puts the pointer at 3
        req_valid = 4'b0100;
        tick();
        chk("skip_setup_id", 64'(out_id), 64'h2);
        req_valid = 4'b0010;
        settle();
        chk("skip_ready_1", 64'(req_ready), 64'h2);
        tick();
        chk("skip_id_1", 64'(out_id), 64'h1);
        req_valid = 4'hF;
        settle();
        chk("skip_ptr_is_2", 64'(req_ready), 64'h4);
        req_valid = 4'b0001;
        settle();
        chk("wrap_ready_0", 64'(req_ready), 64'h1);
        tick();
        chk("wrap_id_0",   64'(out_id),   64'h0);
        chk("wrap_data_0", 64'(out_data), 64'hFFFFF00D);
        req_valid = 4'hF;
        out_ready = 1'b0;
        settle();
        chk("wrap_stall_ready", 64'(req_ready), 64'h0);
        out_ready = 1'b1;
        settle();
        chk("wrap_ptr_is_1", 64'(req_ready), 64'h2);

        // 6: reset while a result is held
        out_ready = 1'b0;
        #2;
        chk("mid_pre_valid", 64'(out_valid), 64'h1);
        rst_n = 1'b0;
        settle();
        chk("mid_rst_valid", 64'(out_valid), 64'h0);
        chk("mid_rst_data",  64'(out_data),  64'h0);
        chk("mid_rst_id",    64'(out_id),    64'h0);
        chk("mid_rst_ready", 64'(req_ready), 64'h0);
        tick();
        req_valid = 4'h0;
        rst_n     = 1'b1;
        tick();
        chk("post_rst_no_stale", 64'(out_valid), 64'h0);
        req_valid = 4'hF;
        out_ready = 1'b1;
        settle();
        chk("post_rst_ptr_0", 64'(req_ready), 64'h1);
        tick();
        chk("post_rst_id",   64'(out_id),    64'h0);
        chk("post_rst_valid", 64'(out_valid), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
